xtor_core_pipe: RTL and testbench

- Parametrised successor to the single-register transactor core.
- Accepts words on a valid/ready input channel and applies a runtime-selectable arithmetic op (pass/add/xor/sub with a programmable operand).
- Buffers results in a DEPTH-entry FIFO and presents them on a valid/ready output channel with true backpressure.
- Sits between a testbench driver/BFM and the DUT-facing side of transactor fabrics.

---
 rtl/xtor_core_pkg.sv | 40 ++++
 rtl/xtor_sync_fifo.sv | 56 +++++
 rtl/xtor_core_pipe.sv | 125 ++++++++++++
 tb/tb_xtor_core_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/xtor_core_pkg.sv
// xtor_core_pkg: shared types and the arithmetic helper for the transactor pipe core.
//   op_e      : runtime op select (PASS/ADD/XOR/SUB)
//   state_e   : core control FSM states
//   apply_op  : result = data <op> operand, modulo 2^MAX_DATA_W (callers truncate)
package xtor_core_pkg;

  // Widest DATA_W the helper supports; callers cast to/from their own width.
  localparam int unsigned MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_ADD  = 2'd1,
    OP_XOR  = 2'd2,
    OP_SUB  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_FLUSH
  } state_e;

  // Low DATA_W bits of the wide result are exact for add/sub modulo 2^DATA_W.
  function automatic logic [MAX_DATA_W-1:0] apply_op(
    input op_e                   op,
    input logic [MAX_DATA_W-1:0] data,
    input logic [MAX_DATA_W-1:0] operand
  );
    logic [MAX_DATA_W-1:0] res;
    unique case (op)
      OP_PASS: res = data;
      OP_ADD:  res = data + operand;
      OP_XOR:  res = data ^ operand;
      OP_SUB:  res = data - operand;
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/xtor_sync_fifo.sv
// xtor_sync_fifo: single-clock FIFO with extra-MSB pointers.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, din    : write din at the tail (ignored when full)
//   pop          : advance the head (ignored when empty)
//   clear        : drop all entries (pointers to zero), overrides push/pop
//   full, empty  : occupancy == DEPTH / occupancy == 0
//   count        : occupancy, 0..DEPTH
//   head         : entry at the read pointer (meaningful only when !empty)
module xtor_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DATA_W-1:0]        head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  // Same slot index, different lap bit: writer is one full lap ahead.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/xtor_core_pipe.sv
// xtor_core_pipe: valid/ready transactor core applying a selectable op and
// buffering results in a DEPTH-entry FIFO with true output backpressure.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   flush               : one-cycle request to discard buffered entries
//   mode, operand       : op select (PASS/ADD/XOR/SUB) and its second operand
//   in_valid/in_ready/in_data    : input channel
//   out_valid/out_ready/out_data : output channel (out_data = FIFO head)
//   busy                : FIFO non-empty or FSM not in RUN
// Optional (macro XTOR_CORE_PIPE_STATS_EN):
//   xfer_count, stall_count : saturating pop / stall-cycle counters
module xtor_core_pipe
  import xtor_core_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] operand,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
`ifdef XTOR_CORE_PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DATA_W > MAX_DATA_W || CNT_W == 0)
  begin : g_bad_cfg
    $error("xtor_core_pipe: unsupported DATA_W/DEPTH/CNT_W");
  end

  state_e                 state;
  state_e                 state_n;
  logic                   flush_now;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [DATA_W-1:0]      fifo_head;
  logic [DATA_W-1:0]      result;
  logic [DATA_W-1:0]      out_hold;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_INIT;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    flush_now = 1'b0;
    busy      = 1'b1;
    unique case (state)
      ST_INIT:  state_n = ST_RUN;
      ST_RUN: begin
        in_ready  = !fifo_full;
        out_valid = !fifo_empty;
        flush_now = flush;
        busy      = (fifo_count != '0);
        if (flush) state_n = ST_FLUSH;
      end
      ST_FLUSH: state_n = ST_RUN;
      default:  state_n = ST_INIT;
    endcase
  end

  // A flush in the same cycle as a handshake wins: the FIFO is cleared and
  // neither the push nor the pop takes effect.
  assign fifo_push = in_valid && in_ready && !flush_now;
  assign fifo_pop  = out_valid && out_ready && !flush_now;

  assign result = DATA_W'(apply_op(op_e'(mode), MAX_DATA_W'(in_data), MAX_DATA_W'(operand)));

  xtor_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush_now),
    .din   (result),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // The FIFO RAM slot under the read pointer is stale once drained, so the
  // last presented word is shadowed here and shown while out_valid is low.
  always_ff @(posedge clock) begin
    if (reset)          out_hold <= '0;
    else if (out_valid) out_hold <= fifo_head;
  end

  assign out_data = out_valid ? fifo_head : out_hold;

`ifdef XTOR_CORE_PIPE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_pop && xfer_count != '1)
        xfer_count <= xfer_count + CNT_W'(1);
      if (out_valid && !out_ready && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_xtor_core_pipe.sv
module tb_xtor_core_pipe;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [1:0]  mode;
  logic [31:0] operand;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
`ifdef XTOR_CORE_PIPE_STATS_EN
  logic [15:0] xfer_count;
  logic [15:0] stall_count;
`endif

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb [$];

  xtor_core_pipe #(
    .DATA_W (32),
    .DEPTH  (4),
    .CNT_W  (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .mode      (mode),
    .operand   (operand),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef XTOR_CORE_PIPE_STATS_EN
    ,
    .xfer_count  (xfer_count),
    .stall_count (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d, input logic [31:0] o);
    case (m)
      2'd0:    return d;
      2'd1:    return d + o;
      2'd2:    return d ^ o;
      default: return d - o;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: score the handshakes that the coming edge will complete.
  task automatic tick();
    @(negedge clock);
    if (reset) begin
      sb.delete();
    end else begin
      check("out_valid_vs_sb", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("pop_unexpected", out_data, 32'hDEAD_BEEF);
          else                check("pop_data", out_data, sb.pop_front());
        end
        if (in_valid && in_ready) sb.push_back(model(mode, in_data, operand));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 32) begin
      tick();
      n++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; mode = 2'd0; operand = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset and release
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 1);
    reset = 1'b0;
    check("init_in_ready", in_ready, 0);
    tick();
    check("run_in_ready", in_ready, 1);
    check("run_busy", busy, 0);

    // ADD with wrap
    mode = 2'd1; operand = 32'd1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h0000_0005;
    check("add_no_bypass", out_valid, 0);
    tick();
    in_data = 32'hFFFF_FFFF;
    check("add_valid", out_valid, 1);
    check("add_data", out_data, 32'h0000_0006);
    tick();
    in_valid = 1'b0;
    check("add_wrap", out_data, 32'h0000_0000);
    tick();
    check("add_empty", out_valid, 0);
    check("add_idle", busy, 0);

    // Backpressure: four fill the FIFO, fifth waits for space
    mode = 2'd0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + i;
      tick();
    end
    check("bp_full_in_ready", in_ready, 0);
    check("bp_head", out_data, 32'h100);
    check("bp_busy", busy, 1);
    in_data = 32'h104;
    tick(); tick();
    check("bp_still_full", in_ready, 0);
    check("bp_head_stable", out_data, 32'h100);
    out_ready = 1'b1;
    tick();
    check("bp_space", in_ready, 1);
    check("bp_head2", out_data, 32'h101);
    tick();
    in_valid = 1'b0;
    check("bp_head3", out_data, 32'h102);
    drain();
    check("bp_drained", out_valid, 0);

    // Mode change mid-stream
    mode = 2'd3; operand = 32'd3; in_valid = 1'b1; in_data = 32'd10;
    tick();
    mode = 2'd2; operand = 32'hF; in_data = 32'hA0;
    check("mc_sub", out_data, 32'd7);
    tick();
    in_valid = 1'b0;
    check("mc_xor", out_data, 32'hAF);
    tick();
    check("mc_empty", out_valid, 0);

    // Flush with three buffered entries and a simultaneous push
    mode = 2'd0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h11 * (i + 1);
      tick();
    end
    check("fl_ready_before", in_ready, 1);
    flush = 1'b1; in_data = 32'h999;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 0);
    check("fl_busy", busy, 1);
    check("fl_hold", out_data, 32'h11);
    tick();
    check("fl_resume_ready", in_ready, 1);
    check("fl_resume_valid", out_valid, 0);
    check("fl_resume_idle", busy, 0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    check("fl_fresh", out_data, 32'h55);
    tick();
    check("fl_no_stale", out_valid, 0);

    // Reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h66; tick();
    in_data = 32'h77; tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("mr_out_valid", out_valid, 0);
    check("mr_in_ready", in_ready, 0);
    check("mr_out_data", out_data, 0);
    check("mr_busy", busy, 1);
    reset = 1'b0;
    tick();
    check("mr_run", in_ready, 1);

    // Four pops after six stall cycles
`ifdef XTOR_CORE_PIPE_STATS_EN
    check("st_xfer0", 32'(xfer_count), 0);
    check("st_stall0", 32'(stall_count), 0);
`endif
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h200 + i;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("st_empty", out_valid, 0);
    check("st_sb_empty", sb.size(), 0);
`ifdef XTOR_CORE_PIPE_STATS_EN
    check("st_xfer", 32'(xfer_count), 4);
    check("st_stall", 32'(stall_count), 6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
